// File: rtl/qr_pkg.sv
// Shared types and helpers for the zone centre finder: scan state encoding,
// default coordinate/address widths, and the per-axis zone range helper.
package qr_pkg;

  localparam int COORD_W_DEF = 9;
  localparam int ADDR_W_DEF  = 20;
  // Widest zone grid the range helper supports on one axis.
  localparam int MAX_ZONES   = 16;
  // Boundaries are widened to this width before range evaluation.
  localparam int RANGE_W     = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_WAIT,
    ST_SAMPLE,
    ST_CLOSE,
    ST_DONE
  } scan_state_t;

  typedef struct packed {
    logic [RANGE_W-1:0] lo;
    logic [RANGE_W-1:0] hi;
  } zone_range_t;

  // Inclusive pixel range of zone idx on one axis. The first zone starts at 0,
  // the last ends at limit-1, interior edges come from the boundary list, so a
  // boundary pixel belongs to both neighbouring zones.
  function automatic zone_range_t zone_range(
    input int                           idx,
    input int                           nzones,
    input logic [MAX_ZONES*RANGE_W-1:0] bounds,
    input int                           limit
  );
    zone_range_t r;
    r.lo = '0;
    r.hi = RANGE_W'(limit - 1);
    if (idx > 0 && idx < MAX_ZONES) r.lo = bounds[(idx-1)*RANGE_W +: RANGE_W];
    if (idx < nzones - 1 && idx < MAX_ZONES) r.hi = bounds[idx*RANGE_W +: RANGE_W];
    return r;
  endfunction

endpackage

// File: rtl/zone_raster_scanner.sv
// Raster walker over a grid of zones: holds the captured boundaries, the zone
// indices and the current pixel, and flags end of zone / end of frame.
module zone_raster_scanner
  import qr_pkg::*;
#(
  parameter int WIDTH   = 480,
  parameter int HEIGHT  = 480,
  parameter int ZONES_X = 3,
  parameter int ZONES_Y = 3,
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             capture,
  input  logic                             advance,
  input  logic                             next_zone,
  input  logic [(ZONES_X-1)*COORD_W-1:0]   bound_x,
  input  logic [(ZONES_Y-1)*COORD_W-1:0]   bound_y,
  output logic [COORD_W-1:0]               x,
  output logic [COORD_W-1:0]               y,
  output logic                             last_pixel,
  output logic                             last_zone,
  output logic                             next_empty
);

  localparam int ZXW = (ZONES_X > 1) ? $clog2(ZONES_X) : 1;
  localparam int ZYW = (ZONES_Y > 1) ? $clog2(ZONES_Y) : 1;

  logic [(ZONES_X-1)*COORD_W-1:0] bx_q;
  logic [(ZONES_Y-1)*COORD_W-1:0] by_q;
  logic [ZXW-1:0]                 zx, nzx;
  logic [ZYW-1:0]                 zy, nzy;
  logic [MAX_ZONES*RANGE_W-1:0]   bx_w, by_w;
  zone_range_t                    rx, ry, nrx, nry;

  // Widen the captured boundaries into the helper's fixed-width layout.
  always_comb begin
    bx_w = '0;
    by_w = '0;
    for (int i = 0; i < ZONES_X - 1; i++) bx_w[i*RANGE_W +: RANGE_W] = RANGE_W'(bx_q[i*COORD_W +: COORD_W]);
    for (int i = 0; i < ZONES_Y - 1; i++) by_w[i*RANGE_W +: RANGE_W] = RANGE_W'(by_q[i*COORD_W +: COORD_W]);
  end

  // Successor zone in x-fastest order, and ranges of current and next zone.
  always_comb begin
    if (int'(zx) == ZONES_X - 1) begin
      nzx = '0;
      nzy = zy + ZYW'(1);
    end else begin
      nzx = zx + ZXW'(1);
      nzy = zy;
    end
    rx  = zone_range(int'(zx),  ZONES_X, bx_w, WIDTH);
    ry  = zone_range(int'(zy),  ZONES_Y, by_w, HEIGHT);
    nrx = zone_range(int'(nzx), ZONES_X, bx_w, WIDTH);
    nry = zone_range(int'(nzy), ZONES_Y, by_w, HEIGHT);
  end

  assign last_pixel = (RANGE_W'(x) == rx.hi) && (RANGE_W'(y) == ry.hi);
  assign last_zone  = (int'(zx) == ZONES_X - 1) && (int'(zy) == ZONES_Y - 1);
  assign next_empty = (nrx.lo > nrx.hi) || (nry.lo > nry.hi);

  // Capture bounds at start, then step pixels inside a zone or jump to the next zone's corner.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      bx_q <= '0;
      by_q <= '0;
      zx   <= '0;
      zy   <= '0;
      x    <= '0;
      y    <= '0;
    end else if (capture) begin
      bx_q <= bound_x;
      by_q <= bound_y;
      zx   <= '0;
      zy   <= '0;
      x    <= '0;
      y    <= '0;
    end else if (next_zone) begin
      zx <= nzx;
      zy <= nzy;
      x  <= COORD_W'(nrx.lo);
      y  <= COORD_W'(nry.lo);
    end else if (advance) begin
      if (RANGE_W'(x) == rx.hi) begin
        x <= COORD_W'(rx.lo);
        y <= y + COORD_W'(1);
      end else begin
        x <= x + COORD_W'(1);
      end
    end
  end

endmodule

// File: rtl/zone_center_finder.sv
// Zone centre finder: scans each zone's candidate pixels (horizontal AND
// vertical pattern hits), samples them from the frame buffer and records one
// centre per zone that is black above THRESH_NUM/8.
//
// Handshake: start_in is accepted only while busy_out is low (IDLE); busy_out
// rises on the following cycle and stays high until the cycle done_out pulses.
// Centres, count and flags are valid from done_out until the next accepted start.
module zone_center_finder
  import qr_pkg::*;
#(
  parameter int WIDTH        = 480,
  parameter int HEIGHT       = 480,
  parameter int ZONES_X      = 3,
  parameter int ZONES_Y      = 3,
  parameter int READ_LATENCY = 2,
  parameter int MAX_CENTERS  = 3,
  parameter int THRESH_NUM   = 7,
  parameter int COORD_W      = COORD_W_DEF,
  parameter int ADDR_W       = ADDR_W_DEF
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic                                 start_in,
  input  logic [WIDTH-1:0]                     horz_patterns,
  input  logic [HEIGHT-1:0]                    vert_patterns,
  input  logic [(ZONES_X-1)*COORD_W-1:0]       bound_x,
  input  logic [(ZONES_Y-1)*COORD_W-1:0]       bound_y,
  input  logic                                 pixel_in,
  output logic [ADDR_W-1:0]                    address_out,
  output logic [MAX_CENTERS*COORD_W-1:0]       centers_x,
  output logic [MAX_CENTERS*COORD_W-1:0]       centers_y,
  output logic [$clog2(MAX_CENTERS+1)-1:0]     center_count,
  output logic                                 busy_out,
  output logic                                 done_out,
  output logic                                 too_many_out,
  output logic                                 too_few_out
);

  localparam int CNT_W = $clog2(WIDTH*HEIGHT+1);
  localparam int TW    = CNT_W + 4;
  localparam int CCW   = $clog2(MAX_CENTERS+1);
  localparam int WW    = $clog2(READ_LATENCY+1);

  scan_state_t        state;
  logic [COORD_W-1:0] x, y;
  logic [COORD_W-1:0] first_x, first_y, last_x, last_y;
  logic               first_valid;
  logic [CNT_W-1:0]   black_cnt, white_cnt;
  logic [WW-1:0]      wait_cnt;
  logic               overflow;
  logic               last_pixel, last_zone, next_empty;
  logic               cand;
  logic               qualify;
  logic [WIDTH-1:0]   h_sh;
  logic [HEIGHT-1:0]  v_sh;
  logic [TW-1:0]      black_w, total_w, thresh_w;
  logic [COORD_W:0]   sum_x, sum_y;

  zone_raster_scanner #(
    .WIDTH   (WIDTH),
    .HEIGHT  (HEIGHT),
    .ZONES_X (ZONES_X),
    .ZONES_Y (ZONES_Y),
    .COORD_W (COORD_W)
  ) u_scanner (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .capture    ((state == ST_IDLE) && start_in),
    .advance    (((state == ST_SCAN) && !cand && !last_pixel) || ((state == ST_SAMPLE) && !last_pixel)),
    .next_zone  ((state == ST_CLOSE) && !last_zone),
    .bound_x    (bound_x),
    .bound_y    (bound_y),
    .x          (x),
    .y          (y),
    .last_pixel (last_pixel),
    .last_zone  (last_zone),
    .next_empty (next_empty)
  );

  assign address_out = ADDR_W'(y) * ADDR_W'(WIDTH) + ADDR_W'(x);

  // Candidate test, threshold decision and midpoint of the zone's candidate span.
  always_comb begin
    h_sh     = horz_patterns >> x;
    v_sh     = vert_patterns >> y;
    cand     = h_sh[0] & v_sh[0];
    black_w  = TW'(black_cnt) << 3;
    total_w  = TW'(black_cnt) + TW'(white_cnt);
    thresh_w = total_w * TW'(THRESH_NUM);
    qualify  = (total_w != '0) && (black_w > thresh_w);
    sum_x    = {1'b0, first_x} + {1'b0, last_x};
    sum_y    = {1'b0, first_y} + {1'b0, last_y};
  end

  // Scan FSM with candidate counts, centre store and result flags.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state        <= ST_IDLE;
      busy_out     <= 1'b0;
      done_out     <= 1'b0;
      too_many_out <= 1'b0;
      too_few_out  <= 1'b0;
      center_count <= '0;
      centers_x    <= '0;
      centers_y    <= '0;
      overflow     <= 1'b0;
      black_cnt    <= '0;
      white_cnt    <= '0;
      wait_cnt     <= '0;
      first_valid  <= 1'b0;
      first_x      <= '0;
      first_y      <= '0;
      last_x       <= '0;
      last_y       <= '0;
    end else begin
      done_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_in) begin
            busy_out     <= 1'b1;
            too_many_out <= 1'b0;
            too_few_out  <= 1'b0;
            center_count <= '0;
            centers_x    <= '0;
            centers_y    <= '0;
            overflow     <= 1'b0;
            black_cnt    <= '0;
            white_cnt    <= '0;
            first_valid  <= 1'b0;
            state        <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (cand) begin
            last_x <= x;
            last_y <= y;
            if (!first_valid) begin
              first_x     <= x;
              first_y     <= y;
              first_valid <= 1'b1;
            end
            wait_cnt <= '0;
            state    <= ST_WAIT;
          end else if (last_pixel) begin
            state <= ST_CLOSE;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == WW'(READ_LATENCY - 1)) state <= ST_SAMPLE;
          else wait_cnt <= wait_cnt + WW'(1);
        end
        ST_SAMPLE: begin
          if (pixel_in) white_cnt <= white_cnt + CNT_W'(1);
          else          black_cnt <= black_cnt + CNT_W'(1);
          state <= last_pixel ? ST_CLOSE : ST_SCAN;
        end
        ST_CLOSE: begin
          if (qualify) begin
            if (center_count < CCW'(MAX_CENTERS)) begin
              centers_x[center_count*COORD_W +: COORD_W] <= sum_x[COORD_W:1];
              centers_y[center_count*COORD_W +: COORD_W] <= sum_y[COORD_W:1];
              center_count <= center_count + CCW'(1);
            end else begin
              overflow <= 1'b1;
            end
          end
          black_cnt   <= '0;
          white_cnt   <= '0;
          first_valid <= 1'b0;
          first_x     <= '0;
          first_y     <= '0;
          last_x      <= '0;
          last_y      <= '0;
          if (last_zone)       state <= ST_DONE;
          else if (next_empty) state <= ST_CLOSE;
          else                 state <= ST_SCAN;
        end
        ST_DONE: begin
          done_out     <= 1'b1;
          busy_out     <= 1'b0;
          too_many_out <= overflow;
          too_few_out  <= (center_count < CCW'(MAX_CENTERS));
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zone_center_finder.sv
// Directed bench for zone_center_finder on a 64x64 frame with a 3x3 zone grid.
module tb_zone_center_finder;

  localparam int W  = 64;
  localparam int H  = 64;
  localparam int CW = 9;
  localparam int AW = 20;
  localparam int MC = 3;
  localparam int TIMEOUT = 20000;

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic             start_in;
  logic [W-1:0]     horz_patterns;
  logic [H-1:0]     vert_patterns;
  logic [2*CW-1:0]  bound_x, bound_y;
  logic             pixel_in;
  logic [AW-1:0]    address_out;
  logic [MC*CW-1:0] centers_x, centers_y;
  logic [1:0]       center_count;
  logic             busy_out, done_out, too_many_out, too_few_out;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [2*CW-1:0] exp_q[$];

  // Frame buffer model: 1 marks a black pixel; data returns two cycles after the address.
  bit          black_px [0:W*H-1];
  logic [AW-1:0] a_d1, a_d2;

  zone_center_finder #(
    .WIDTH(W), .HEIGHT(H), .ZONES_X(3), .ZONES_Y(3), .READ_LATENCY(2),
    .MAX_CENTERS(MC), .THRESH_NUM(7), .COORD_W(CW), .ADDR_W(AW)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
    .horz_patterns(horz_patterns), .vert_patterns(vert_patterns),
    .bound_x(bound_x), .bound_y(bound_y), .pixel_in(pixel_in),
    .address_out(address_out), .centers_x(centers_x), .centers_y(centers_y),
    .center_count(center_count), .busy_out(busy_out), .done_out(done_out),
    .too_many_out(too_many_out), .too_few_out(too_few_out)
  );

  // Clock and frame-buffer read pipeline.
  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    a_d1 <= address_out;
    a_d2 <= a_d1;
  end

  assign pixel_in = ~black_px[a_d2[11:0]];

  // ---------------- driver tasks ----------------
  task automatic clear_setup();
    for (int i = 0; i < W*H; i++) black_px[i] = 1'b0;
    horz_patterns = '0;
    vert_patterns = '0;
    bound_x = {9'd42, 9'd21};
    bound_y = {9'd42, 9'd21};
  endtask

  task automatic paint(input int x0, input int y0, input int x1, input int y1);
    for (int yy = y0; yy <= y1; yy++)
      for (int xx = x0; xx <= x1; xx++) black_px[yy*W + xx] = 1'b1;
  endtask

  task automatic set_bits(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      horz_patterns[i] = 1'b1;
      vert_patterns[i] = 1'b1;
    end
  endtask

  // Start a scan and count clock edges from acceptance until done_out shows.
  task automatic run_scan(input bit glitch, output int lat);
    @(negedge clk_in);
    start_in = 1'b1;
    @(posedge clk_in);
    #1 start_in = 1'b0;
    lat = TIMEOUT;
    for (int i = 1; i <= TIMEOUT; i++) begin
      @(posedge clk_in);
      #1;
      if (glitch && i == 4) start_in = 1'b1;
      if (glitch && i == 7) start_in = 1'b0;
      if (done_out) begin
        lat = i;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_in = 1'b1;
    start_in = 1'b0;
    clear_setup();
    repeat (3) @(posedge clk_in);
    #1;
    chk_cnt++; if (busy_out !== 1'b0 || done_out !== 1'b0) $display("FAIL reset_busy_done: got %b%b expected 00", busy_out, done_out); else pass_cnt++;
    chk_cnt++; if (center_count !== 2'd0) $display("FAIL reset_count: got %0d expected 0", center_count); else pass_cnt++;
    chk_cnt++; if (too_many_out !== 1'b0 || too_few_out !== 1'b0) $display("FAIL reset_flags: got %b%b expected 00", too_many_out, too_few_out); else pass_cnt++;
    chk_cnt++; if (centers_x !== '0 || centers_y !== '0 || address_out !== '0) $display("FAIL reset_outputs: got %h %h %h expected 0", centers_x, centers_y, address_out); else pass_cnt++;
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  task automatic test_all_zero();
    int lat;
    clear_setup();
    run_scan(1'b0, lat);
    chk_cnt++; if (lat !== 1 + 66*66 + 9) $display("FAIL zero_latency: got %0d expected %0d", lat, 1 + 66*66 + 9); else pass_cnt++;
    chk_cnt++; if (center_count !== 2'd0) $display("FAIL zero_count: got %0d expected 0", center_count); else pass_cnt++;
    chk_cnt++; if (too_few_out !== 1'b1 || too_many_out !== 1'b0) $display("FAIL zero_flags: got few=%b many=%b expected few=1 many=0", too_few_out, too_many_out); else pass_cnt++;
    chk_cnt++; if (busy_out !== 1'b0) $display("FAIL zero_busy: got %b expected 0", busy_out); else pass_cnt++;
  endtask

  task automatic test_single_square();
    int lat;
    clear_setup();
    bound_x = {9'd50, 9'd30};
    bound_y = {9'd50, 9'd30};
    set_bits(10, 19);
    paint(10, 10, 19, 19);
    run_scan(1'b0, lat);
    // 100 candidates each cost 4 cycles instead of 1.
    chk_cnt++; if (lat !== 1 + 66*66 + 100*3 + 9) $display("FAIL square_latency: got %0d expected %0d", lat, 1 + 66*66 + 300 + 9); else pass_cnt++;
    chk_cnt++; if (center_count !== 2'd1) $display("FAIL square_count: got %0d expected 1", center_count); else pass_cnt++;
    chk_cnt++; if (centers_x[8:0] !== 9'd14 || centers_y[8:0] !== 9'd14) $display("FAIL square_centre: got (%0d,%0d) expected (14,14)", centers_x[8:0], centers_y[8:0]); else pass_cnt++;
    chk_cnt++; if (too_few_out !== 1'b1 || too_many_out !== 1'b0) $display("FAIL square_flags: got few=%b many=%b expected few=1 many=0", too_few_out, too_many_out); else pass_cnt++;
  endtask

  task automatic test_three_squares(input bit fourth);
    int lat;
    logic [2*CW-1:0] e;
    clear_setup();
    set_bits(2, 7);
    set_bits(50, 55);
    paint(2, 2, 7, 7);
    paint(50, 2, 55, 7);
    paint(2, 50, 7, 55);
    if (fourth) paint(50, 50, 55, 55);
    exp_q.push_back({9'd4, 9'd4});
    exp_q.push_back({9'd52, 9'd4});
    exp_q.push_back({9'd4, 9'd52});
    run_scan(1'b0, lat);
    chk_cnt++; if (lat !== 1 + 66*66 + 144*3 + 9) $display("FAIL squares_latency: got %0d expected %0d", lat, 1 + 66*66 + 432 + 9); else pass_cnt++;
    chk_cnt++; if (center_count !== 2'd3) $display("FAIL squares_count: got %0d expected 3", center_count); else pass_cnt++;
    for (int i = 0; i < MC; i++) begin
      e = exp_q.pop_front();
      chk_cnt++;
      if ({centers_x[i*CW +: CW], centers_y[i*CW +: CW]} !== e)
        $display("FAIL squares_slot%0d: got (%0d,%0d) expected (%0d,%0d)", i, centers_x[i*CW +: CW], centers_y[i*CW +: CW], e[17:9], e[8:0]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (too_many_out !== fourth || too_few_out !== 1'b0) $display("FAIL squares_flags: got many=%b few=%b expected many=%b few=0", too_many_out, too_few_out, fourth);
    else pass_cnt++;
  endtask

  task automatic test_threshold();
    int lat;
    clear_setup();
    for (int i = 5; i <= 12; i++) horz_patterns[i] = 1'b1;
    vert_patterns[5] = 1'b1;
    paint(5, 5, 11, 5);
    run_scan(1'b0, lat);
    chk_cnt++; if (center_count !== 2'd0) $display("FAIL thresh_7of8: got count %0d expected 0", center_count); else pass_cnt++;
    chk_cnt++; if (too_few_out !== 1'b1) $display("FAIL thresh_7of8_few: got %b expected 1", too_few_out); else pass_cnt++;
    paint(12, 5, 12, 5);
    run_scan(1'b0, lat);
    chk_cnt++; if (center_count !== 2'd1) $display("FAIL thresh_8of8: got count %0d expected 1", center_count); else pass_cnt++;
    chk_cnt++; if (centers_x[8:0] !== 9'd8 || centers_y[8:0] !== 9'd5) $display("FAIL thresh_centre: got (%0d,%0d) expected (8,5)", centers_x[8:0], centers_y[8:0]); else pass_cnt++;
  endtask

  task automatic test_shared_boundary();
    int lat;
    clear_setup();
    horz_patterns[21] = 1'b1;
    vert_patterns[5]  = 1'b1;
    paint(21, 5, 21, 5);
    run_scan(1'b0, lat);
    chk_cnt++; if (center_count !== 2'd2) $display("FAIL shared_count: got %0d expected 2", center_count); else pass_cnt++;
    chk_cnt++;
    if (centers_x[17:0] !== {9'd21, 9'd21} || centers_y[17:0] !== {9'd5, 9'd5})
      $display("FAIL shared_centres: got x=%h y=%h expected x=%h y=%h", centers_x[17:0], centers_y[17:0], {9'd21, 9'd21}, {9'd5, 9'd5});
    else pass_cnt++;
  endtask

  task automatic test_empty_zone();
    int lat;
    clear_setup();
    bound_x = {9'd20, 9'd30};
    run_scan(1'b0, lat);
    // Column widths 31, 0 and 44; the empty column costs only its CLOSE cycles.
    chk_cnt++; if (lat !== 1 + 75*66 + 9) $display("FAIL empty_latency: got %0d expected %0d", lat, 1 + 75*66 + 9); else pass_cnt++;
  endtask

  task automatic test_start_ignored();
    int lat;
    int extra;
    clear_setup();
    run_scan(1'b1, lat);
    chk_cnt++; if (lat !== 1 + 66*66 + 9) $display("FAIL busy_start_latency: got %0d expected %0d", lat, 1 + 66*66 + 9); else pass_cnt++;
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_in);
      #1;
      if (done_out || busy_out) extra++;
    end
    chk_cnt++; if (extra !== 0) $display("FAIL busy_start_extra: got %0d active cycles expected 0", extra); else pass_cnt++;
  endtask

  task automatic test_reset_mid_wait();
    int lat;
    int seen;
    clear_setup();
    horz_patterns[0] = 1'b1;
    vert_patterns[0] = 1'b1;
    paint(0, 0, 0, 0);
    @(negedge clk_in);
    start_in = 1'b1;
    @(posedge clk_in);
    #1 start_in = 1'b0;
    @(posedge clk_in);
    #1;
    chk_cnt++; if (busy_out !== 1'b1) $display("FAIL midwait_busy: got %b expected 1", busy_out); else pass_cnt++;
    rst_in = 1'b1;
    #1;
    chk_cnt++; if (busy_out !== 1'b0 || done_out !== 1'b0) $display("FAIL midwait_reset_busy: got %b%b expected 00", busy_out, done_out); else pass_cnt++;
    chk_cnt++; if (center_count !== 2'd0 || centers_x !== '0 || too_few_out !== 1'b0) $display("FAIL midwait_reset_outputs: got count=%0d x=%h few=%b expected 0", center_count, centers_x, too_few_out); else pass_cnt++;
    @(negedge clk_in);
    rst_in = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_in);
      #1;
      if (done_out || busy_out) seen++;
    end
    chk_cnt++; if (seen !== 0) $display("FAIL midwait_no_done: got %0d active cycles expected 0", seen); else pass_cnt++;
    run_scan(1'b0, lat);
    chk_cnt++; if (lat !== 1 + 66*66 + 3 + 9 || center_count !== 2'd1) $display("FAIL midwait_rescan: got lat=%0d count=%0d expected lat=%0d count=1", lat, center_count, 1 + 66*66 + 3 + 9); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_single_square();
    test_three_squares(1'b0);
    test_three_squares(1'b1);
    test_threshold();
    test_shared_boundary();
    test_empty_zone();
    test_start_ignored();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
